byte_order_stage: RTL and testbench
===================================

Name: byte_order_stage

Overview:
- Registered, parametrised byte-order converter for the AES datapath.
- Applies one of four per-beat permutations: pass, full byte reverse, per-word byte reverse, or square-state transpose (row-major <-> column-major).
- Sits between the key/data load path and the round core.
- valid/ready handshake on both sides, a 2-entry skid buffer, 1-cycle latency, full throughput.

Parameters:
- NB, 128, data width in bits; must be a multiple of BYTE.
- BYTE, 8, bits per byte lane.
- WORD_BYTES, 4, bytes per word for mode 2; NB/BYTE must be a multiple of it.
- DIM, 4, state-matrix side for mode 3; mode 3 is legal only when NB/BYTE == DIM*DIM.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- clr  input  1  synchronous flush; discards all held beats.
- in_valid  input  1  input beat valid.
- in_ready  output  1  stage can accept a beat.
- in_mode  input  2  permutation for this beat: 0 pass, 1 byte reverse, 2 word-byte reverse, 3 transpose.
- in_data  input  NB  input beat.
- out_valid  output  1  output beat valid.
- out_ready  input  1  downstream accepts.
- out_data  output  NB  permuted beat.
- mode_err  output  1  sticky flag: mode 3 requested with an illegal geometry.

Behaviour:
- Byte lane k is bits [BYTE*k +: BYTE]; N = NB/BYTE.
- Mode 0: out lane k = in lane k.
- Mode 1: out lane k = in lane N-1-k.
- Mode 2: out lane g*WORD_BYTES+j = in lane g*WORD_BYTES+WORD_BYTES-1-j.
- Mode 3 (N == DIM*DIM): out lane c*DIM+r = in lane r*DIM+c.
- Mode 3 with N != DIM*DIM: the beat passes unchanged (mode 0) and mode_err sets.
- Permutation is applied combinationally on input; the permuted beat is registered. in_mode is sampled with its beat only.
- Accept: in_valid && in_ready at a rising edge. Deliver: out_valid && out_ready.
- Storage: main register (drives out_*) plus one skid register.
- in_ready = !skid_valid, registered; never combinationally dependent on out_ready.
- Accept with main empty, or with main being delivered in the same cycle: beat goes to main.
- Accept with main full and not delivered: beat goes to skid.
- Deliver with skid full: skid moves to main; in_ready rises the next cycle.
- Latency: a beat accepted at edge t is visible on out_data after edge t (out_valid high in cycle t+1) when the stage was empty.
- Throughput: 1 beat/cycle sustained while out_ready is held high.
- Stall: out_data/out_valid hold stable while out_valid && !out_ready.
- Full (main and skid valid): in_ready = 0; in_valid is ignored.
- Simultaneous accept and deliver: order is preserved, no beat is lost or duplicated.
- clr: next edge clears main_valid and skid_valid, sets in_ready = 1; any beat offered that cycle is dropped. clr takes priority over accept/deliver. mode_err is unaffected.
- Reset (async assert, any time incl. mid-transfer): out_valid = 0, out_data = 0, in_ready = 1, mode_err = 0, skid cleared.
- Reset release: synchronous to clk; the first accept is possible on the first edge with rst_n high.
- mode_err: set on accept of a mode-3 beat with an illegal geometry; cleared only by rst_n.

Test Plan:
- Mode sweep, NB=128, in_data=128'h000102030405060708090a0b0c0d0e0f, out_ready=1:
  - mode 0 -> identical.
  - mode 1 -> 128'h0f0e0d0c0b0a09080706050403020100.
  - mode 2 -> 128'h03020100070605040b0a09080f0e0d0c.
  - mode 3 -> 128'h0004080c0105090d02060a0e03070b0f.
  - each appears 1 cycle after accept.
- Back-to-back: 8 beats of incrementing data, mixed modes, out_ready=1 -> 8 outputs on 8 consecutive cycles, in_ready stays 1, order preserved.
- Backpressure: out_ready=0 while 3 beats are offered -> beats 1-2 accepted, in_ready=0 after the 2nd, beat 3 held upstream, out_data stable. Raise out_ready -> beats 1, 2, 3 delivered in order, no gaps after release.
- Flush: stage full, assert clr one cycle with in_valid=1 -> next cycle out_valid=0, in_ready=1, offered beat not delivered.
- Reset mid-operation: rst_n low asynchronously between edges with main and skid full -> out_valid=0, out_data=0, in_ready=1 immediately. Beat after release is the first delivered.
- Illegal geometry: NB=64, DIM=4, mode 3 beat 64'h0001020304050607 -> output 64'h0001020304050607, mode_err=1 and stays 1 across later legal beats and clr, clears only on rst_n.

Source files
------------

// File: rtl/byte_order_stage.sv
// byte_order_stage: registered byte-lane permutation (pass/reverse/word-reverse/transpose) behind a 2-entry skid buffer
module byte_order_stage #(
   parameter int NB         = 128,
   parameter int BYTE       = 8,
   parameter int WORD_BYTES = 4,
   parameter int DIM        = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [1:0]    in_mode,
   input  logic [NB-1:0] in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [NB-1:0] out_data,
   output logic          mode_err
);
   localparam int N  = NB / BYTE;
   localparam bit SQ = (N == DIM * DIM);
   logic [NB-1:0] rev, wrev, tr, perm;
   logic [NB-1:0] main_q, main_d, skid_q, skid_d;
   logic          main_v_q, main_v_d, skid_v_q, skid_v_d, err_q, err_d;
   logic          acc, dlv;
   for (genvar k = 0; k < N; k++) begin : g_lane
      assign rev[BYTE*k +: BYTE]  = in_data[BYTE*(N-1-k) +: BYTE];
      assign wrev[BYTE*k +: BYTE] = in_data[BYTE*((k/WORD_BYTES)*WORD_BYTES + WORD_BYTES-1-k%WORD_BYTES) +: BYTE];
      // Non-square geometry falls back to pass-through; mode_err flags it
      if (SQ) begin : g_tr
         assign tr[BYTE*k +: BYTE] = in_data[BYTE*((k%DIM)*DIM + k/DIM) +: BYTE];
      end else begin : g_pass
         assign tr[BYTE*k +: BYTE] = in_data[BYTE*k +: BYTE];
      end
   end
   assign perm = in_mode == 2'd0 ? in_data : in_mode == 2'd1 ? rev : in_mode == 2'd2 ? wrev : tr;
   assign acc  = in_valid && !skid_v_q;
   assign dlv  = main_v_q && out_ready;
   always_comb begin
      main_d   = main_q;
      main_v_d = main_v_q;
      skid_d   = skid_q;
      skid_v_d = skid_v_q;
      err_d    = err_q | (acc && !clr && in_mode == 2'd3 && !SQ);
      if (clr) begin
         main_v_d = 1'b0;
         skid_v_d = 1'b0;
      end else if (skid_v_q) begin
         if (dlv) begin
            main_d   = skid_q;
            skid_v_d = 1'b0;
         end
      end else if (acc && main_v_q && !dlv) begin
         skid_d   = perm;
         skid_v_d = 1'b1;
      end else if (acc) begin
         main_d   = perm;
         main_v_d = 1'b1;
      end else if (dlv) begin
         main_v_d = 1'b0;
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_q   <= '0;
         skid_q   <= '0;
         main_v_q <= 1'b0;
         skid_v_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         main_q   <= main_d;
         skid_q   <= skid_d;
         main_v_q <= main_v_d;
         skid_v_q <= skid_v_d;
         err_q    <= err_d;
      end
   end
   assign in_ready  = !skid_v_q;
   assign out_valid = main_v_q;
   assign out_data  = main_q;
   assign mode_err  = err_q;
endmodule

// File: tb/tb_byte_order_stage.sv
// tb_byte_order_stage: scoreboard bench for byte_order_stage (128-bit legal and 64-bit illegal-geometry instances)
module tb_byte_order_stage;
   localparam logic [127:0] D = 128'h000102030405060708090a0b0c0d0e0f;
   logic [127:0] sweep [4] = '{128'h000102030405060708090a0b0c0d0e0f,
                               128'h0f0e0d0c0b0a09080706050403020100,
                               128'h03020100070605040b0a09080f0e0d0c,
                               128'h0004080c0105090d02060a0e03070b0f};
   logic         clk = 1'b0, rst_n = 1'b0;
   logic         clr = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
   logic         in_ready, out_valid, mode_err;
   logic [1:0]   in_mode = 2'd0;
   logic [127:0] in_data = '0, out_data;
   logic         clr2 = 1'b0, in_valid2 = 1'b0, out_ready2 = 1'b1;
   logic         in_ready2, out_valid2, mode_err2;
   logic [1:0]   in_mode2 = 2'd0;
   logic [63:0]  in_data2 = '0, out_data2;
   logic [127:0] q1 [$];
   logic [63:0]  q2 [$];
   int           nvec = 0, nerr = 0;

   always #5 clk = ~clk;

   byte_order_stage u_dut (
      .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
      .in_mode(in_mode), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .mode_err(mode_err));

   byte_order_stage #(.NB(64), .DIM(4)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .clr(clr2), .in_valid(in_valid2), .in_ready(in_ready2),
      .in_mode(in_mode2), .in_data(in_data2), .out_valid(out_valid2), .out_ready(out_ready2),
      .out_data(out_data2), .mode_err(mode_err2));

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [127:0] ref_perm(input logic [127:0] d, input logic [1:0] m);
      logic [127:0] r;
      r = '0;
      for (int i = 0; i < 16; i++) begin
         int s;
         s = m == 2'd0 ? i : m == 2'd1 ? 15 - i : m == 2'd2 ? (i / 4) * 4 + 3 - i % 4 : 4 * (i % 4) + i / 4;
         r[8*i +: 8] = d[8*s +: 8];
      end
      return r;
   endfunction

   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready && !clr) begin
         if (q1.size() == 0) begin
            nvec++;
            nerr++;
            $display("FAIL sb1_unexpected: got %h with no beat expected", out_data);
         end else check("sb1", out_data, q1.pop_front());
      end
   end

   always @(negedge clk) begin
      if (rst_n && out_valid2 && out_ready2 && !clr2) begin
         if (q2.size() == 0) begin
            nvec++;
            nerr++;
            $display("FAIL sb2_unexpected: got %h with no beat expected", out_data2);
         end else check("sb2", 128'(out_data2), 128'(q2.pop_front()));
      end
   end

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [127:0] d, input logic [1:0] m, input logic [127:0] e);
      bit ok = 1'b0;
      in_valid = 1'b1;
      in_data  = d;
      in_mode  = m;
      for (int i = 0; i < 50 && !ok; i++) begin
         ok = in_ready;
         if (ok) q1.push_back(e);
         @(posedge clk);
         #1;
      end
      if (!ok) begin
         nvec++;
         nerr++;
         $display("FAIL send_timeout: got in_ready=0 for 50 cycles, expected acceptance");
      end
      in_valid = 1'b0;
   endtask

   task automatic send2(input logic [63:0] d, input logic [1:0] m, input logic [63:0] e);
      bit ok = 1'b0;
      in_valid2 = 1'b1;
      in_data2  = d;
      in_mode2  = m;
      for (int i = 0; i < 50 && !ok; i++) begin
         ok = in_ready2;
         if (ok) q2.push_back(e);
         @(posedge clk);
         #1;
      end
      if (!ok) begin
         nvec++;
         nerr++;
         $display("FAIL send2_timeout: got in_ready=0 for 50 cycles, expected acceptance");
      end
      in_valid2 = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 20 && (q1.size() != 0 || q2.size() != 0); i++) begin
         @(posedge clk);
         #1;
      end
      check("q1_drained", q1.size(), 0);
      check("q2_drained", q2.size(), 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      #2;
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_mode_err", mode_err, 0);
      check("rst_mode_err2", mode_err2, 0);
      #10 rst_n = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      for (int m = 0; m < 4; m++) begin
         send(D, m[1:0], sweep[m]);
         check("lat_out_valid", out_valid, 1);
         check("lat_out_data", out_data, sweep[m]);
         idle(1);
      end
      check("legal_mode3_no_err", mode_err, 0);
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1;
         in_data  = D + 128'(i);
         in_mode  = i[1:0];
         q1.push_back(ref_perm(in_data, in_mode));
         check("b2b_in_ready", in_ready, 1);
         @(posedge clk);
         #1;
         check("b2b_out_valid", out_valid, 1);
      end
      idle(1);
      drain();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = D;
      in_mode   = 2'd1;
      q1.push_back(sweep[1]);
      @(posedge clk);
      #1;
      check("bp_ready_after_1", in_ready, 1);
      in_mode = 2'd2;
      q1.push_back(sweep[2]);
      @(posedge clk);
      #1;
      check("bp_ready_after_2", in_ready, 0);
      in_mode = 2'd3;
      repeat (3) begin
         @(posedge clk);
         #1;
         check("bp_hold_ready", in_ready, 0);
         check("bp_stall_valid", out_valid, 1);
         check("bp_stall_data", out_data, sweep[1]);
      end
      out_ready = 1'b1;
      send(D, 2'd3, sweep[3]);
      check("bp_no_gap", out_valid, 1);
      drain();
      out_ready = 1'b0;
      send(D, 2'd0, D);
      send(D, 2'd1, sweep[1]);
      check("fl_full", in_ready, 0);
      clr      = 1'b1;
      in_valid = 1'b1;
      in_data  = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;
      in_mode  = 2'd0;
      @(posedge clk);
      #1;
      clr      = 1'b0;
      in_valid = 1'b0;
      q1.delete();
      check("fl_out_valid", out_valid, 0);
      check("fl_in_ready", in_ready, 1);
      out_ready = 1'b1;
      idle(3);
      check("fl_no_output", out_valid, 0);
      send2(64'h0001020304050607, 2'd3, 64'h0001020304050607);
      check("err_set", mode_err2, 1);
      idle(1);
      send2(64'h0001020304050607, 2'd1, 64'h0706050403020100);
      check("err_sticky_legal", mode_err2, 1);
      idle(1);
      clr2 = 1'b1;
      @(posedge clk);
      #1;
      clr2 = 1'b0;
      check("err_sticky_clr", mode_err2, 1);
      drain();
      out_ready = 1'b0;
      send(D, 2'd2, sweep[2]);
      send(D, 2'd3, sweep[3]);
      check("rs_full", in_ready, 0);
      #3 rst_n = 1'b0;
      #1;
      check("rs_out_valid", out_valid, 0);
      check("rs_out_data", out_data, 0);
      check("rs_in_ready", in_ready, 1);
      check("rs_mode_err2", mode_err2, 0);
      q1.delete();
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      send(128'h112233445566778899aabbccddeeff00, 2'd1, 128'h00ffeeddccbbaa998877665544332211);
      check("rs_first_out", out_data, 128'h00ffeeddccbbaa998877665544332211);
      idle(1);
      drain();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
